gpu_gp0_write_arbiter: RTL and testbench
========================================

Name: gpu_gp0_write_arbiter

Overview:
Shares the single GP0 command-FIFO write port between two requesters: direct CPU writes to GPU+0 and DMA channel-2 writes.
- CPU writes have no back-pressure, so they land in a small buffer.
- DMA uses a valid/ready handshake and gets bounded bursts so the CPU buffer cannot starve.
- Also generates the registered DMA request (GPUSTAT bit 25) from the GP1(04h) DMA direction.
- Sits between the CPU/DMA bus decode and the GP0 command FIFO, alongside the GP1 register frontend.

Parameters:
- CPU_DEPTH, 4, CPU buffer entries; power of two, minimum 2.
- DMA_BURST, 16, max DMA words accepted consecutively while a CPU word is pending.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_cpuWrite  in  1  CPU write strobe to GPU+0 (gpuSel & write & !A2), single cycle
- i_cpuData  in  32  CPU write data
- i_dmaValid  in  1  DMA word available
- i_dmaData  in  32  DMA word
- o_dmaReady  out  1  DMA word accepted this cycle
- i_fifoAlmostFull  in  1  command FIFO has fewer than 2 free entries
- o_fifoWrite  out  1  command FIFO push (registered)
- o_fifoData  out  32  command FIFO data (registered)
- i_rstCmd  in  1  GP1(01h) command flush pulse
- i_dmaDir  in  2  DMADirection from the GP1 registers
- i_gpuReadReady  in  1  GPUREAD data available (VRAM→CPU copy)
- o_dmaRequest  out  1  DMA request / GPUSTAT bit 25 (registered)
- o_cpuOverflow  out  1  sticky flag: a CPU write was dropped because the buffer was full
- o_cpuPending  out  1  CPU buffer non-empty

Behaviour:
- **Reset** (i_rst): buffer empty, owner=NONE, burstCnt=0. All outputs 0: o_fifoWrite, o_fifoData, o_dmaRequest, o_cpuOverflow, o_cpuPending, o_dmaReady.
- **CPU buffer**: FIFO with CPU_DEPTH entries.
  - Push on i_cpuWrite when not full.
  - A push while full drops the word and sets o_cpuOverflow; the flag clears only on reset or i_rstCmd.
  - Push and pop in the same cycle while full are legal: pop first, so nothing is dropped.
- **Owner register**: NONE / CPU / DMA.
- **Grant** (combinational, evaluated each cycle):
  - owner=CPU and buffer non-empty → CPU.
  - Else owner=DMA and i_dmaValid and (burstCnt<DMA_BURST or buffer empty) → DMA.
  - Else buffer non-empty → CPU.
  - Else i_dmaValid → DMA.
  - Else none.
- **Transfer** occurs only when grant≠none and !i_fifoAlmostFull and !i_rstCmd.
  - CPU grant: pop the buffer.
  - DMA grant: o_dmaReady=1, DMA word taken.
  - Next edge: o_fifoWrite=1 and o_fifoData=transferred word. Otherwise o_fifoWrite=0 and o_fifoData holds its value.
- **Owner/counter update**:
  - No transfer: owner and burstCnt hold.
  - Transfer: owner ← granted source.
  - burstCnt resets to 1 on a DMA transfer when the previous owner≠DMA. It increments on each further DMA transfer, saturating at DMA_BURST.
  - A cycle with grant=none sets owner=NONE.
- **Latency**:
  - CPU write in cycle N → o_fifoWrite in N+2 at the earliest.
  - DMA accept in cycle K → o_fifoWrite in K+1.
- **Ordering**: words within each source are preserved.
- **Flush** (i_rstCmd), highest priority:
  - Same cycle: no transfer, o_dmaReady=0, an i_cpuWrite in that cycle is dropped (no overflow flag).
  - Next edge: buffer empty, owner=NONE, burstCnt=0, o_cpuOverflow=0, o_fifoWrite=0.
- **o_dmaRequest** (registered, next edge):
  - DMA_DirOff → 0.
  - DMA_DirFIFO and DMA_DirCPUtoGP0 → !i_fifoAlmostFull & !o_cpuPending.
  - DMA_DirGPUREADtoCPU → i_gpuReadReady.
- **o_cpuPending**: combinational from the buffer's empty flag.

Decomposition:
- Package gpu_pkg: DMADirection enum (DMA_DirOff, DMA_DirFIFO, DMA_DirCPUtoGP0, DMA_DirGPUREADtoCPU) and the owner enum (ARB_NONE, ARB_CPU, ARB_DMA).
- One sub-module, gpu_small_fifo (parameterised depth/width, same-cycle push/pop, flush input), used for the CPU buffer.

Test Plan:
- **Basic CPU path**: single CPU write 32'hE1000123 in cycle 0, FIFO not full → o_fifoWrite=1, o_fifoData=E1000123 in cycle 2 only.
- **Overflow**: hold i_fifoAlmostFull=1, issue 5 CPU writes 1..5 → o_cpuOverflow=1, o_cpuPending=1. Release → o_fifoWrite high 4 consecutive cycles carrying 1,2,3,4; no 5.
- **Burst fairness**: continuous i_dmaValid with data D0.., then one CPU write C after D2 is accepted (DMA_BURST=16) → D0..D15, then C, then D16; o_dmaReady low exactly in C's transfer cycle.
- **Back-pressure**: i_fifoAlmostFull=1 for 3 cycles mid-DMA → o_dmaReady=0 and o_fifoWrite=0 those cycles (after one-cycle output lag); no word lost or duplicated.
- **Flush**: i_rstCmd coincides with a CPU write, buffer holding 2 words, o_cpuOverflow=1 → nothing reaches the FIFO; next cycle o_cpuPending=0, o_cpuOverflow=0.
- **DMA request**:
  - i_dmaDir=0 → o_dmaRequest=0.
  - i_dmaDir=2 with FIFO free and buffer empty → 1 one cycle later; i_fifoAlmostFull=1 → 0 one cycle later.
  - i_dmaDir=3 → o_dmaRequest follows i_gpuReadReady with one-cycle lag.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU enums: GP1(04h) DMA direction codes and GP0 write-port owner.
// Latency: n/a (types only).  Backpressure: n/a.
package gpu_pkg;

    typedef enum logic [1:0] {
        DMA_DirOff          = 2'd0,
        DMA_DirFIFO         = 2'd1,
        DMA_DirCPUtoGP0     = 2'd2,
        DMA_DirGPUREADtoCPU = 2'd3
    } dma_dir_e;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/gpu_small_fifo.sv
// Small power-of-two FIFO with same-cycle push/pop and synchronous flush.
// Latency: push visible at head next cycle.  Backpressure: push while full accepted only alongside a pop.
module gpu_small_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_empty,
    output logic             o_full
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign o_empty   = (count_q == '0);
    assign o_full    = (count_q == FULL_CNT);
    assign o_pop_dat = mem_q[rd_ptr_q];

    // Pop frees the slot first, so a push into a full FIFO with a pop is kept.
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/gpu_gp0_write_arbiter.sv
// Arbitrates CPU (buffered) and DMA (valid/ready) writes onto the GP0 command FIFO; drives GPUSTAT.25.
// Latency: DMA accept -> push 1 cycle; CPU write -> push 2 cycles min.  Backpressure: i_fifoAlmostFull stalls all transfers.
module gpu_gp0_write_arbiter
    import gpu_pkg::*;
#(
    parameter int CPU_DEPTH = 4,
    parameter int DMA_BURST = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpuWrite,
    input  logic [31:0] i_cpuData,
    input  logic        i_dmaValid,
    input  logic [31:0] i_dmaData,
    output logic        o_dmaReady,
    input  logic        i_fifoAlmostFull,
    output logic        o_fifoWrite,
    output logic [31:0] o_fifoData,
    input  logic        i_rstCmd,
    input  logic [1:0]  i_dmaDir,
    input  logic        i_gpuReadReady,
    output logic        o_dmaRequest,
    output logic        o_cpuOverflow,
    output logic        o_cpuPending
);

    localparam int            CW        = $clog2(DMA_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(DMA_BURST);

    arb_owner_e    owner_q, owner_d, grant;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          fifo_write_q, fifo_write_d;
    logic [31:0]   fifo_data_q, fifo_data_d;
    logic          dma_request_q, dma_request_d;
    logic          cpu_overflow_q, cpu_overflow_d;
    logic          cpu_empty, cpu_full, cpu_pop, xfer;
    logic [31:0]   cpu_head;

    gpu_small_fifo #(
        .DEPTH (CPU_DEPTH),
        .WIDTH (32)
    ) u_cpu_buf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_rstCmd),
        .i_push     (i_cpuWrite & ~i_rstCmd),
        .i_push_dat (i_cpuData),
        .i_pop      (cpu_pop),
        .o_pop_dat  (cpu_head),
        .o_empty    (cpu_empty),
        .o_full     (cpu_full)
    );

    // The current owner keeps the port; DMA yields to a pending CPU word once its burst is spent.
    always_comb begin
        grant = ARB_NONE;
        if (owner_q == ARB_CPU && !cpu_empty) begin
            grant = ARB_CPU;
        end else if (owner_q == ARB_DMA && i_dmaValid && (burst_cnt_q < BURST_MAX || cpu_empty)) begin
            grant = ARB_DMA;
        end else if (!cpu_empty) begin
            grant = ARB_CPU;
        end else if (i_dmaValid) begin
            grant = ARB_DMA;
        end
    end

    assign xfer         = (grant != ARB_NONE) & ~i_fifoAlmostFull & ~i_rstCmd & ~i_rst;
    assign cpu_pop      = xfer & (grant == ARB_CPU);
    assign o_dmaReady   = xfer & (grant == ARB_DMA);
    assign o_cpuPending = ~cpu_empty;

    always_comb begin
        owner_d        = owner_q;
        burst_cnt_d    = burst_cnt_q;
        fifo_write_d   = xfer;
        fifo_data_d    = fifo_data_q;
        cpu_overflow_d = cpu_overflow_q | (i_cpuWrite & cpu_full & ~cpu_pop);
        dma_request_d  = 1'b0;

        if (xfer) begin
            fifo_data_d = cpu_pop ? cpu_head : i_dmaData;
        end

        if (i_rstCmd) begin
            owner_d        = ARB_NONE;
            burst_cnt_d    = '0;
            cpu_overflow_d = 1'b0;
        end else if (grant == ARB_NONE) begin
            owner_d = ARB_NONE;
        end else if (xfer) begin
            owner_d = grant;
            if (grant == ARB_DMA) begin
                if (owner_q != ARB_DMA) begin
                    burst_cnt_d = CW'(1);
                end else if (burst_cnt_q < BURST_MAX) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end
        end

        case (dma_dir_e'(i_dmaDir))
            DMA_DirFIFO, DMA_DirCPUtoGP0: dma_request_d = ~i_fifoAlmostFull & ~o_cpuPending;
            DMA_DirGPUREADtoCPU:          dma_request_d = i_gpuReadReady;
            default:                      dma_request_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            owner_q        <= ARB_NONE;
            burst_cnt_q    <= '0;
            fifo_write_q   <= 1'b0;
            fifo_data_q    <= '0;
            dma_request_q  <= 1'b0;
            cpu_overflow_q <= 1'b0;
        end else begin
            owner_q        <= owner_d;
            burst_cnt_q    <= burst_cnt_d;
            fifo_write_q   <= fifo_write_d;
            fifo_data_q    <= fifo_data_d;
            dma_request_q  <= dma_request_d;
            cpu_overflow_q <= cpu_overflow_d;
        end
    end

    assign o_fifoWrite   = fifo_write_q;
    assign o_fifoData    = fifo_data_q;
    assign o_dmaRequest  = dma_request_q;
    assign o_cpuOverflow = cpu_overflow_q;

endmodule

// File: tb/tb_gpu_gp0_write_arbiter.sv
// Self-checking bench for gpu_gp0_write_arbiter: directed scenarios plus a randomized scoreboard run.
module tb_gpu_gp0_write_arbiter;

    localparam int CPU_DEPTH = 4;
    localparam int DMA_BURST = 16;

    logic        clk = 1'b0;
    logic        i_rst, i_cpuWrite, i_dmaValid, i_fifoAlmostFull, i_rstCmd, i_gpuReadReady;
    logic [31:0] i_cpuData, i_dmaData;
    logic [1:0]  i_dmaDir;
    logic        o_dmaReady, o_fifoWrite, o_dmaRequest, o_cpuOverflow, o_cpuPending;
    logic [31:0] o_fifoData;

    // Outputs captured at the falling edge of the current cycle.
    logic        c_rdy, c_fw, c_req, c_ovf, c_pend;
    logic [31:0] c_fd;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpu_gp0_write_arbiter #(
        .CPU_DEPTH (CPU_DEPTH),
        .DMA_BURST (DMA_BURST)
    ) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_cpuWrite       (i_cpuWrite),
        .i_cpuData        (i_cpuData),
        .i_dmaValid       (i_dmaValid),
        .i_dmaData        (i_dmaData),
        .o_dmaReady       (o_dmaReady),
        .i_fifoAlmostFull (i_fifoAlmostFull),
        .o_fifoWrite      (o_fifoWrite),
        .o_fifoData       (o_fifoData),
        .i_rstCmd         (i_rstCmd),
        .i_dmaDir         (i_dmaDir),
        .i_gpuReadReady   (i_gpuReadReady),
        .o_dmaRequest     (o_dmaRequest),
        .o_cpuOverflow    (o_cpuOverflow),
        .o_cpuPending     (o_cpuPending)
    );

    task automatic cyc();
        @(negedge clk);
        c_rdy  = o_dmaReady;
        c_fw   = o_fifoWrite;
        c_fd   = o_fifoData;
        c_req  = o_dmaRequest;
        c_ovf  = o_cpuOverflow;
        c_pend = o_cpuPending;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        cyc();
        cyc();
        checks++; if (c_fw !== 1'b0)    begin errs++; $display("FAIL reset_fifoWrite got=%b exp=0", c_fw); end
        checks++; if (c_fd !== 32'h0)   begin errs++; $display("FAIL reset_fifoData got=%h exp=0", c_fd); end
        checks++; if (c_req !== 1'b0)   begin errs++; $display("FAIL reset_dmaRequest got=%b exp=0", c_req); end
        checks++; if (c_ovf !== 1'b0)   begin errs++; $display("FAIL reset_overflow got=%b exp=0", c_ovf); end
        checks++; if (c_pend !== 1'b0)  begin errs++; $display("FAIL reset_pending got=%b exp=0", c_pend); end
        checks++; if (c_rdy !== 1'b0)   begin errs++; $display("FAIL reset_dmaReady got=%b exp=0", c_rdy); end
        i_rst = 1'b0;
        cyc();
    endtask

    task automatic test_cpu_basic();
        for (int t = 0; t < 5; t++) begin
            logic exp_fw;
            i_cpuWrite = (t == 0);
            i_cpuData  = (t == 0) ? 32'hE100_0123 : 32'h0;
            cyc();
            exp_fw = (t == 2);
            checks++;
            if (c_fw !== exp_fw) begin errs++; $display("FAIL cpu_basic_fw t=%0d got=%b exp=%b", t, c_fw, exp_fw); end
            if (t == 2) begin
                checks++;
                if (c_fd !== 32'hE100_0123) begin errs++; $display("FAIL cpu_basic_data got=%h exp=e1000123", c_fd); end
            end
            if (t == 1) begin
                checks++;
                if (c_pend !== 1'b1) begin errs++; $display("FAIL cpu_basic_pending got=%b exp=1", c_pend); end
            end
        end
        i_cpuWrite = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] got[$];
        int first = -1;
        int last  = -1;
        i_fifoAlmostFull = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            i_cpuWrite = 1'b1;
            i_cpuData  = 32'(i);
            cyc();
        end
        i_cpuWrite = 1'b0;
        cyc();
        checks++; if (c_ovf !== 1'b1)  begin errs++; $display("FAIL ovf_flag got=%b exp=1", c_ovf); end
        checks++; if (c_pend !== 1'b1) begin errs++; $display("FAIL ovf_pending got=%b exp=1", c_pend); end
        i_fifoAlmostFull = 1'b0;
        for (int t = 0; t < 8; t++) begin
            cyc();
            if (c_fw) begin
                got.push_back(c_fd);
                if (first < 0) first = t;
                last = t;
            end
        end
        checks++;
        if (got.size() != 4) begin
            errs++; $display("FAIL ovf_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== 32'(i + 1)) begin errs++; $display("FAIL ovf_word%0d got=%h exp=%h", i, got[i], 32'(i + 1)); end
            end
            checks++;
            if (last - first != 3) begin errs++; $display("FAIL ovf_consecutive got=%0d exp=3", last - first); end
        end
        checks++; if (c_ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky got=%b exp=1", c_ovf); end
        i_rstCmd = 1'b1;
        cyc();
        i_rstCmd = 1'b0;
        cyc();
        checks++; if (c_ovf !== 1'b0) begin errs++; $display("FAIL ovf_clear got=%b exp=0", c_ovf); end
    endtask

    task automatic test_burst_fairness();
        localparam logic [31:0] CWORD = 32'hC0DE_0001;
        logic [31:0] got[$];
        int acc = 0;
        bit c_sent = 0;
        int low_cnt = 0;
        int low_cycle = -1;
        int c_out_cycle = -1;
        i_dmaValid = 1'b1;
        for (int t = 0; t < 42; t++) begin
            i_dmaValid = (t < 40);
            i_dmaData  = 32'hD000_0000 + 32'(acc);
            i_cpuWrite = (acc == 3) && !c_sent;
            i_cpuData  = CWORD;
            if (i_cpuWrite) c_sent = 1;
            cyc();
            i_cpuWrite = 1'b0;
            if (c_fw) begin
                got.push_back(c_fd);
                if (c_fd === CWORD) c_out_cycle = t;
            end
            if (t < 40) begin
                if (c_rdy) acc++;
                else begin low_cnt++; low_cycle = t; end
            end
        end
        checks++;
        if (got.size() < 18) begin
            errs++; $display("FAIL burst_count got=%0d exp>=18", got.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                logic [31:0] exp;
                exp = (i < 16) ? 32'hD000_0000 + 32'(i) : (i == 16) ? CWORD : 32'hD000_0010;
                checks++;
                if (got[i] !== exp) begin errs++; $display("FAIL burst_word%0d got=%h exp=%h", i, got[i], exp); end
            end
        end
        checks++; if (low_cnt != 1) begin errs++; $display("FAIL burst_ready_low_cycles got=%0d exp=1", low_cnt); end
        checks++; if (c_out_cycle != low_cycle + 1) begin errs++; $display("FAIL burst_cpu_slot got=%0d exp=%0d", c_out_cycle, low_cycle + 1); end
    endtask

    task automatic test_back_pressure();
        int acc = 0;
        int nxt = 0;
        logic prev_exp_rdy = 1'b0;
        for (int t = 0; t < 14; t++) begin
            logic exp_rdy;
            i_dmaValid       = (t < 12);
            i_fifoAlmostFull = (t >= 4 && t <= 6);
            i_dmaData        = 32'hB000_0000 + 32'(acc);
            cyc();
            exp_rdy = (t < 12) && !(t >= 4 && t <= 6);
            checks++;
            if (c_rdy !== exp_rdy) begin errs++; $display("FAIL bp_ready t=%0d got=%b exp=%b", t, c_rdy, exp_rdy); end
            checks++;
            if (c_fw !== prev_exp_rdy) begin errs++; $display("FAIL bp_fw t=%0d got=%b exp=%b", t, c_fw, prev_exp_rdy); end
            if (c_fw) begin
                checks++;
                if (c_fd !== 32'hB000_0000 + 32'(nxt)) begin errs++; $display("FAIL bp_data got=%h exp=%h", c_fd, 32'hB000_0000 + 32'(nxt)); end
                nxt++;
            end
            if (c_rdy) acc++;
            prev_exp_rdy = exp_rdy;
        end
        i_fifoAlmostFull = 1'b0;
        checks++; if (acc != 9 || nxt != 9) begin errs++; $display("FAIL bp_totals got=%0d/%0d exp=9/9", acc, nxt); end
    endtask

    task automatic test_flush();
        i_fifoAlmostFull = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            i_cpuWrite = 1'b1;
            i_cpuData  = 32'hF000_0000 + 32'(i);
            cyc();
        end
        i_cpuWrite       = 1'b0;
        i_fifoAlmostFull = 1'b0;
        cyc();
        cyc();
        i_fifoAlmostFull = 1'b1;
        cyc();
        checks++; if (c_fw !== 1'b1 || c_fd !== 32'hF000_0002) begin errs++; $display("FAIL flush_prefill got=%b/%h exp=1/f0000002", c_fw, c_fd); end
        checks++; if (c_ovf !== 1'b1 || c_pend !== 1'b1) begin errs++; $display("FAIL flush_pre_state got=%b%b exp=11", c_ovf, c_pend); end
        i_rstCmd         = 1'b1;
        i_cpuWrite       = 1'b1;
        i_cpuData        = 32'hF000_00FF;
        i_fifoAlmostFull = 1'b0;
        i_dmaValid       = 1'b1;
        i_dmaData        = 32'hAAAA_0000;
        cyc();
        checks++; if (c_rdy !== 1'b0) begin errs++; $display("FAIL flush_ready got=%b exp=0", c_rdy); end
        i_rstCmd   = 1'b0;
        i_cpuWrite = 1'b0;
        i_dmaValid = 1'b0;
        for (int t = 0; t < 5; t++) begin
            cyc();
            checks++;
            if (c_fw !== 1'b0) begin errs++; $display("FAIL flush_fw t=%0d got=%b exp=0", t, c_fw); end
            if (t == 0) begin
                checks++;
                if (c_pend !== 1'b0 || c_ovf !== 1'b0) begin errs++; $display("FAIL flush_state got=%b%b exp=00", c_pend, c_ovf); end
            end
        end
    endtask

    task automatic test_dma_request();
        logic prev_grr;
        i_dmaDir = 2'd0; i_gpuReadReady = 1'b1; i_fifoAlmostFull = 1'b0;
        cyc(); cyc();
        checks++; if (c_req !== 1'b0) begin errs++; $display("FAIL req_off got=%b exp=0", c_req); end
        i_dmaDir = 2'd2;
        cyc(); cyc();
        checks++; if (c_req !== 1'b1) begin errs++; $display("FAIL req_cpu2gp0_free got=%b exp=1", c_req); end
        i_fifoAlmostFull = 1'b1;
        cyc();
        checks++; if (c_req !== 1'b1) begin errs++; $display("FAIL req_af_lag got=%b exp=1", c_req); end
        cyc();
        checks++; if (c_req !== 1'b0) begin errs++; $display("FAIL req_af got=%b exp=0", c_req); end
        i_dmaDir = 2'd1;
        i_cpuWrite = 1'b1; i_cpuData = 32'h1234_5678;
        cyc();
        i_cpuWrite = 1'b0;
        cyc();
        i_fifoAlmostFull = 1'b0;
        cyc();
        checks++; if (c_pend !== 1'b1) begin errs++; $display("FAIL req_pend_setup got=%b exp=1", c_pend); end
        cyc();
        checks++; if (c_req !== 1'b0) begin errs++; $display("FAIL req_pending got=%b exp=0", c_req); end
        cyc();
        checks++; if (c_req !== 1'b1) begin errs++; $display("FAIL req_pending_clear got=%b exp=1", c_req); end
        i_dmaDir = 2'd3;
        prev_grr = i_gpuReadReady;
        cyc();
        for (int t = 0; t < 12; t++) begin
            i_gpuReadReady = (t % 3 == 0) ? ~prev_grr : 1'($urandom_range(0, 1));
            cyc();
            checks++;
            if (c_req !== prev_grr) begin errs++; $display("FAIL req_gpuread t=%0d got=%b exp=%b", t, c_req, prev_grr); end
            prev_grr = i_gpuReadReady;
        end
        i_dmaDir = 2'd0; i_gpuReadReady = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_random();
        logic [31:0] cpu_q[$];
        logic [31:0] dma_q[$];
        int cpu_next = 0;
        int dma_next = 0;
        int dma_run = 0;
        logic prev_rdy = 1'b0;
        logic [31:0] last_fd;
        logic wr;
        cyc();
        last_fd = c_fd;
        for (int t = 0; t < 840; t++) begin
            if (t < 800) begin
                i_fifoAlmostFull = ($urandom_range(0, 3) == 0);
                i_dmaValid       = ($urandom_range(0, 9) < 6);
                wr               = (cpu_q.size() < CPU_DEPTH) && ($urandom_range(0, 6) == 0);
            end else begin
                i_fifoAlmostFull = 1'b0;
                i_dmaValid       = 1'b0;
                wr               = 1'b0;
            end
            i_dmaData  = 32'(dma_next);
            i_cpuWrite = wr;
            i_cpuData  = 32'h8000_0000 | 32'(cpu_next);
            cyc();
            if (i_fifoAlmostFull || !i_dmaValid) begin
                checks++;
                if (c_rdy !== 1'b0) begin errs++; $display("FAIL rnd_ready_blocked t=%0d got=%b exp=0", t, c_rdy); end
            end
            if (prev_rdy) begin
                checks++;
                if (!(c_fw === 1'b1 && c_fd[31] === 1'b0)) begin errs++; $display("FAIL rnd_dma_lag t=%0d got=%b/%h exp=1/dma", t, c_fw, c_fd); end
            end
            if (c_fw) begin
                checks++;
                if (c_fd[31]) begin
                    if (cpu_q.size() == 0) begin errs++; $display("FAIL rnd_cpu_extra got=%h exp=none", c_fd); end
                    else begin
                        if (c_fd !== cpu_q[0]) begin errs++; $display("FAIL rnd_cpu_order got=%h exp=%h", c_fd, cpu_q[0]); end
                        void'(cpu_q.pop_front());
                    end
                    dma_run = 0;
                end else begin
                    if (dma_q.size() == 0) begin errs++; $display("FAIL rnd_dma_extra got=%h exp=none", c_fd); end
                    else begin
                        if (c_fd !== dma_q[0]) begin errs++; $display("FAIL rnd_dma_order got=%h exp=%h", c_fd, dma_q[0]); end
                        void'(dma_q.pop_front());
                    end
                    if (cpu_q.size() != 0) begin
                        dma_run++;
                        checks++;
                        if (dma_run > DMA_BURST) begin errs++; $display("FAIL rnd_fairness t=%0d got=%0d exp<=%0d", t, dma_run, DMA_BURST); end
                    end
                end
            end else begin
                checks++;
                if (c_fd !== last_fd) begin errs++; $display("FAIL rnd_data_hold t=%0d got=%h exp=%h", t, c_fd, last_fd); end
            end
            last_fd = c_fd;
            if (cpu_q.size() == 0) dma_run = 0;
            checks++;
            if (c_pend !== (cpu_q.size() != 0)) begin errs++; $display("FAIL rnd_pending t=%0d got=%b exp=%b", t, c_pend, cpu_q.size() != 0); end
            checks++;
            if (c_ovf !== 1'b0) begin errs++; $display("FAIL rnd_overflow t=%0d got=%b exp=0", t, c_ovf); end
            if (wr) begin cpu_q.push_back(i_cpuData); cpu_next++; end
            if (c_rdy) begin dma_q.push_back(i_dmaData); dma_next++; end
            prev_rdy = c_rdy;
        end
        checks++;
        if (cpu_q.size() != 0 || dma_q.size() != 0) begin
            errs++; $display("FAIL rnd_drain got=%0d/%0d exp=0/0", cpu_q.size(), dma_q.size());
        end
    endtask

    initial begin
        i_rst = 1'b1; i_cpuWrite = 1'b0; i_cpuData = '0; i_dmaValid = 1'b0; i_dmaData = '0;
        i_fifoAlmostFull = 1'b0; i_rstCmd = 1'b0; i_dmaDir = 2'd0; i_gpuReadReady = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_cpu_basic();
        test_overflow();
        test_burst_fairness();
        test_back_pressure();
        test_flush();
        test_dma_request();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
